// File: rtl/station_array.sv
// station_array
//   Multi-entry reservation station. Holds up to DEPTH in-flight iops, each
//   stepping through its own 3-bit state machine, and presents the oldest
//   issuable entry (LOAD_0/LOAD_1/ALU/STORE) to the scheduler every cycle.
//   Load data returns from the LSU addressed by slot tag.
//
// Ports
//   clk, a_rst_n          clock (rising edge) and async active-low reset
//   id_ack, id_iop*       decode handshake and iop payload (pc, k16, init state)
//   id_feed               at least one entry is free
//   lsu_wb/tag/data       load data return strobe, target slot and data
//   flush                 synchronous discard of every entry
//   r_*                   presented entry: valid, slot, status, payload,
//                         whether an ack this cycle frees it
//   sched_ack             scheduler accepts the presented step
//   r_occupancy           number of entries not in COMPLETE
module station_array #(
    parameter int DEPTH  = 4,
    parameter int SLOT_W = 2,
    parameter int IOP_W  = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic              id_ack,
    input  logic [IOP_W-1:0]  id_iop,
    input  logic [2:0]        id_iop_init,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_k16,
    output logic              id_feed,
    input  logic              lsu_wb,
    input  logic [SLOT_W-1:0] lsu_tag,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              flush,
    output logic              r_valid,
    output logic [SLOT_W-1:0] r_slot,
    output logic [2:0]        r_status,
    output logic [IOP_W-1:0]  r_iop,
    output logic [DATA_W-1:0] r_pc,
    output logic [DATA_W-1:0] r_k16,
    output logic              r_will_complete,
    input  logic              sched_ack,
    output logic [SLOT_W:0]   r_occupancy
);

    typedef enum logic [2:0] {
        COMPLETE = 3'b000,
        WAIT_1   = 3'b001,
        WAIT_2   = 3'b010,
        WAIT_3   = 3'b011,
        LOAD_0   = 3'b100,
        LOAD_1   = 3'b101,
        ALU      = 3'b110,
        STORE    = 3'b111
    } stepState_e;

    stepState_e        stepState_q [DEPTH];
    stepState_e        stepState_d [DEPTH];
    logic [IOP_W-1:0]  iop_q [DEPTH];
    logic [DATA_W-1:0] pc_q  [DEPTH];
    logic [DATA_W-1:0] k16_q [DEPTH];
    // age_q[j][i] set means entry j was allocated before entry i
    logic [DEPTH-1:0]  age_q [DEPTH];
    logic [DEPTH-1:0]  age_d [DEPTH];

    logic [DEPTH-1:0]  freeMask;
    logic [DEPTH-1:0]  issuable;
    logic              allocHit;
    logic [SLOT_W-1:0] allocIdx;
    logic              doAlloc;
    logic              selHit;
    logic              olderFound;
    logic [SLOT_W-1:0] selIdx;
    logic              ackSel;
    logic              selCompletes;

    // Free entries feed the allocator; lowest free index wins
    always_comb begin
        allocHit = 1'b0;
        allocIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            freeMask[i] = (stepState_q[i] == COMPLETE);
            issuable[i] = stepState_q[i][2];
            if (freeMask[i] && !allocHit) begin
                allocHit = 1'b1;
                allocIdx = SLOT_W'(i);
            end
        end
        id_feed = |freeMask;
        // An init state of COMPLETE carries no work, so it must not take a slot
        doAlloc = id_feed & id_ack & (id_iop_init != 3'b000) & ~flush;
    end

    // Oldest issuable entry: no other issuable entry is marked older than it
    always_comb begin
        selHit     = 1'b0;
        selIdx     = '0;
        olderFound = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            olderFound = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && issuable[j] && age_q[j][i]) begin
                    olderFound = 1'b1;
                end
            end
            if (issuable[i] && !olderFound && !selHit) begin
                selHit = 1'b1;
                selIdx = SLOT_W'(i);
            end
        end
    end

    // Presentation outputs are forced to zero when nothing is issuable
    always_comb begin
        r_valid  = |issuable;
        r_slot   = r_valid ? selIdx : '0;
        r_status = r_valid ? stepState_q[selIdx] : 3'b000;
        r_iop    = r_valid ? iop_q[selIdx] : '0;
        r_pc     = r_valid ? pc_q[selIdx] : '0;
        r_k16    = r_valid ? k16_q[selIdx] : '0;
        case (stepState_q[selIdx])
            LOAD_1:  selCompletes = iop_q[selIdx][28];
            ALU:     selCompletes = ~iop_q[selIdx][23];
            STORE:   selCompletes = 1'b1;
            default: selCompletes = 1'b0;
        endcase
        r_will_complete = r_valid & selCompletes;
        ackSel          = r_valid & sched_ack;
    end

    always_comb begin
        r_occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!freeMask[i]) begin
                r_occupancy = r_occupancy + (SLOT_W+1)'(1);
            end
        end
    end

    // Per-entry step machine; flush overrides every other event
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stepState_d[i] = stepState_q[i];
            case (stepState_q[i])
                COMPLETE: if (doAlloc && allocIdx == SLOT_W'(i)) stepState_d[i] = stepState_e'(id_iop_init);
                WAIT_1:   if (lsu_wb && lsu_tag == SLOT_W'(i)) stepState_d[i] = LOAD_1;
                WAIT_2:   if (lsu_wb && lsu_tag == SLOT_W'(i)) stepState_d[i] = ALU;
                WAIT_3:   stepState_d[i] = STORE;
                LOAD_0:   if (ackSel && selIdx == SLOT_W'(i)) stepState_d[i] = WAIT_1;
                LOAD_1:   if (ackSel && selIdx == SLOT_W'(i)) stepState_d[i] = iop_q[i][28] ? COMPLETE : WAIT_2;
                ALU:      if (ackSel && selIdx == SLOT_W'(i)) stepState_d[i] = iop_q[i][23] ? STORE : COMPLETE;
                STORE:    if (ackSel && selIdx == SLOT_W'(i)) stepState_d[i] = COMPLETE;
                default:  stepState_d[i] = stepState_q[i];
            endcase
            if (flush) begin
                stepState_d[i] = COMPLETE;
            end
        end
    end

    // A new entry becomes youngest: it is younger than every other entry,
    // whether live or not; stale bits of free entries are never consulted
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            age_d[j] = age_q[j];
        end
        if (flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                age_d[j] = '0;
            end
        end else if (doAlloc) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (SLOT_W'(j) == allocIdx) begin
                    age_d[j] = '0;
                end else begin
                    age_d[j][allocIdx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stepState_q[i] <= COMPLETE;
                age_q[i]       <= '0;
                iop_q[i]       <= '0;
                pc_q[i]        <= '0;
                k16_q[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stepState_q[i] <= stepState_d[i];
                age_q[i]       <= age_d[i];
                if (doAlloc && allocIdx == SLOT_W'(i)) begin
                    iop_q[i] <= id_iop;
                    pc_q[i]  <= id_pc;
                    k16_q[i] <= id_k16;
                end else if (!flush && lsu_wb && lsu_tag == SLOT_W'(i) &&
                             (stepState_q[i] == WAIT_1 || stepState_q[i] == WAIT_2)) begin
                    k16_q[i] <= lsu_data;
                end
            end
        end
    end

endmodule
